// File: rtl/uart_word.sv
// Word-wide 8N1/8N2 UART with a send/receive/drive-bus/done command model and selectable byte order.
// Optional even parity bit after the data bits when UART_PARITY_EN is defined.
module uart_word #(
  parameter int CLK_DIV    = 26,
  parameter int OVERSAMPLE = 4,
  parameter int WORD_BYTES = 2,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_in_and_send,
  input  logic                      uart_receive,
  input  logic                      uart_out,
  input  logic                      rx,
  output logic                      tx,
  output logic                      uart_done,
  output logic                      rx_error,
  inout  wire  [8*WORD_BYTES-1:0]   DATA
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
    RX_PARITY,
`endif
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_idx;
  logic [7:0]    shift_reg;
  logic [W-1:0]  word_reg;
  logic [W-1:0]  asm_reg;
  logic          rx_meta;
  logic          rx_sync;

  logic          tick;
  logic          bit_end;
  logic          half_end;
  logic          last_byte;
  logic [BW-1:0] slot;
  logic [7:0]    tx_byte;
  logic [W-1:0]  asm_next;

  assign DATA = uart_out ? word_reg : 'z;

  always_comb begin
    tick      = (div_cnt == '0);
    bit_end   = tick && (tick_cnt == TICK_LAST);
    half_end  = tick && (tick_cnt == TICK_HALF);
    last_byte = (byte_idx == BYTE_LAST);
    // Byte index counts wire order; slot is its position inside the word.
    slot      = (MSB_FIRST != 0) ? (BYTE_LAST - byte_idx) : byte_idx;
    tx_byte   = word_reg[{slot, 3'b000} +: 8];
    asm_next  = asm_reg;
    asm_next[{slot, 3'b000} +: 8] = shift_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      uart_done <= 1'b0;
      rx_error  <= 1'b0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      asm_reg   <= '0;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      uart_done <= 1'b0;
      div_cnt   <= tick ? DIV_LAST : div_cnt - 1'b1;
      if (tick) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (uart_in_and_send) begin
            rx_error <= 1'b0;
            word_reg <= DATA;
            byte_idx <= '0;
            tx       <= 1'b0;
            div_cnt  <= DIV_LAST;
            tick_cnt <= '0;
            state    <= TX_START;
          end else if (uart_receive) begin
            rx_error <= 1'b0;
            byte_idx <= '0;
            state    <= RX_WAIT;
          end
        end

        TX_START: begin
          if (bit_end) begin
            tx        <= tx_byte[0];
            shift_reg <= {1'b0, tx_byte[7:1]};
            bit_cnt   <= '0;
            state     <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              tx      <= ^tx_byte;
              state   <= TX_PARITY;
`else
              tx      <= 1'b1;
              bit_cnt <= '0;
              state   <= TX_STOP;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= TX_STOP;
          end
        end
`endif

        TX_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              if (last_byte) begin
                uart_done <= 1'b1;
                state     <= DONE;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                tx       <= 1'b0;
                div_cnt  <= DIV_LAST;
                tick_cnt <= '0;
                state    <= TX_START;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        RX_WAIT: begin
          if (!rx_sync) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= '0;
            state    <= RX_START;
          end
        end

        RX_START: begin
          if (half_end) begin
            if (rx_sync) begin
              state <= RX_WAIT;
            end else begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= RX_DATA;
            end
          end
        end

        RX_DATA: begin
          if (bit_end) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (bit_end) begin
            if (rx_sync != ^shift_reg) rx_error <= 1'b1;
            state <= RX_STOP;
          end
        end
`endif

        RX_STOP: begin
          if (bit_end) begin
            if (!rx_sync) begin
              rx_error  <= 1'b1;
              uart_done <= 1'b1;
              state     <= DONE;
            end else begin
              asm_reg <= asm_next;
              if (last_byte) begin
                word_reg  <= asm_next;
                uart_done <= 1'b1;
                state     <= DONE;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= RX_WAIT;
              end
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word.sv
// Directed/randomised bench for uart_word: two instances (2-byte MSB-first, 4-byte LSB-first)
// checked against a frame-level reference model.
module tb_uart_word;

  localparam int CD = 4;
  localparam int OV = 4;
  localparam int BP = CD * OV;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic send_a, recv_a, out_a, rx_a, tx_a, done_a, err_a, drv_en_a;
  logic send_b, recv_b, out_b, rx_b, tx_b, done_b, err_b, drv_en_b;
  logic [15:0] drv_a;
  logic [31:0] drv_b;
  wire  [15:0] data_a;
  wire  [31:0] data_b;

  assign data_a = drv_en_a ? drv_a : 'z;
  assign data_b = drv_en_b ? drv_b : 'z;

  uart_word #(.CLK_DIV(CD), .OVERSAMPLE(OV), .WORD_BYTES(2), .STOP_BITS(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(rst_n), .uart_in_and_send(send_a), .uart_receive(recv_a),
    .uart_out(out_a), .rx(rx_a), .tx(tx_a), .uart_done(done_a), .rx_error(err_a), .DATA(data_a));

  uart_word #(.CLK_DIV(CD), .OVERSAMPLE(OV), .WORD_BYTES(4), .STOP_BITS(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(rst_n), .uart_in_and_send(send_b), .uart_receive(recv_b),
    .uart_out(out_b), .rx(rx_b), .tx(tx_b), .uart_done(done_b), .rx_error(err_b), .DATA(data_b));

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [31:0] model_word_a;
  logic [31:0] model_word_b;

  always @(posedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: which byte of a word goes on the wire k-th, and what a frame looks like.
  function automatic logic [7:0] wire_byte(input logic [31:0] w, input int k, input int nb, input bit msb);
    int sh;
    sh = msb ? 8 * (nb - 1 - k) : 8 * k;
    return 8'((w >> sh) & 32'hFF);
  endfunction

  function automatic logic [15:0] frame_of(input logic [7:0] b);
    logic [15:0] f;
    f = '0;
    for (int j = 0; j < 8; j++) f[1 + j] = b[j];
`ifdef UART_PARITY_EN
    f[9] = ($countones(b) % 2) == 1;
`endif
    f[FB - 1] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] assemble(input logic [7:0] bs [4], input int nb, input bit msb);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < nb; k++) w = w | (32'(bs[k]) << (msb ? 8 * (nb - 1 - k) : 8 * k));
    return w;
  endfunction

  task automatic cmd(input int sel, input bit is_send, input logic [31:0] w);
    @(posedge clk); #1;
    if (sel == 0) begin
      drv_a = w[15:0]; drv_en_a = is_send;
      if (is_send) send_a = 1'b1; else recv_a = 1'b1;
    end else begin
      drv_b = w; drv_en_b = is_send;
      if (is_send) send_b = 1'b1; else recv_b = 1'b1;
    end
    @(posedge clk); #1;
    send_a = 1'b0; recv_a = 1'b0; drv_en_a = 1'b0;
    send_b = 1'b0; recv_b = 1'b0; drv_en_b = 1'b0;
  endtask

  task automatic run_tx(input int sel, input logic [31:0] w, input string tag);
    int   nb;
    bit   msb;
    int   total;
    int   found;
    int   done_idx;
    int   done_hi;
    logic s[$];
    logic [15:0] got;
    nb = (sel != 0) ? 4 : 2;
    msb = (sel == 0);
    total = nb * FB * BP;
    found = 0; done_idx = -1; done_hi = 0;
    cmd(sel, 1'b1, w);
    if (sel == 0) model_word_a = w & 32'hFFFF; else model_word_b = w;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (((sel != 0) ? tx_b : tx_a) === 1'b0) found = 1;
    end
    check({tag, "_start_seen"}, 64'(found), 64'd1);
    if (found == 0) return;
    s.push_back(1'b0);
    for (int i = 1; i <= total + BP; i++) begin
      @(negedge clk);
      s.push_back((sel != 0) ? tx_b : tx_a);
      if (((sel != 0) ? done_b : done_a) === 1'b1) begin
        if (done_idx < 0) done_idx = i;
        done_hi++;
      end
    end
    for (int k = 0; k < nb; k++) begin
      got = '0;
      for (int j = 0; j < FB; j++) got[j] = s[BP * (k * FB + j) + BP / 2];
      check($sformatf("%s_frame%0d", tag, k), 64'(got), 64'(frame_of(wire_byte(w, k, nb, msb))));
    end
    check({tag, "_done_time"}, 64'(done_idx), 64'(total));
    check({tag, "_done_width"}, 64'(done_hi), 64'd1);
    check({tag, "_tx_idle"}, 64'(s[s.size() - 1]), 64'd1);
  endtask

  task automatic drive_frame(input int sel, input logic [7:0] b, input bit stopv);
    logic [15:0] f;
    f = frame_of(b);
    f[FB - 1] = stopv;
    @(posedge clk); #1;
    for (int j = 0; j < FB; j++) begin
      if (sel == 0) rx_a = f[j]; else rx_b = f[j];
      repeat (BP) @(posedge clk);
      #1;
    end
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
    repeat (2 * BP) @(posedge clk);
  endtask

  task automatic read_word(input int sel, output logic [31:0] w);
    @(posedge clk); #1;
    if (sel == 0) out_a = 1'b1; else out_b = 1'b1;
    @(negedge clk);
    w = (sel != 0) ? data_b : {16'h0, data_a};
    @(posedge clk); #1;
    out_a = 1'b0; out_b = 1'b0;
  endtask

  task automatic run_rx(input int sel, input logic [7:0] bs [4], input string tag);
    int nb;
    int d0;
    logic [31:0] rd;
    logic [31:0] exp;
    nb = (sel != 0) ? 4 : 2;
    d0 = (sel != 0) ? done_cnt_b : done_cnt_a;
    cmd(sel, 1'b0, '0);
    for (int k = 0; k < nb; k++) drive_frame(sel, bs[k], 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp = assemble(bs, nb, sel == 0);
    check({tag, "_done_count"}, 64'(((sel != 0) ? done_cnt_b : done_cnt_a) - d0), 64'd1);
    check({tag, "_rx_error"}, 64'((sel != 0) ? err_b : err_a), 64'd0);
    read_word(sel, rd);
    check({tag, "_word"}, 64'(rd), 64'(exp));
    if (sel == 0) model_word_a = exp; else model_word_b = exp;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bs [4];
    logic [31:0] w;
    logic [31:0] rd;
    int d0;

    rst_n = 1'b0;
    send_a = 0; recv_a = 0; out_a = 1; rx_a = 1; drv_en_a = 0; drv_a = '0;
    send_b = 0; recv_b = 0; out_b = 1; rx_b = 1; drv_en_b = 0; drv_b = '0;
    model_word_a = '0; model_word_b = '0;
    repeat (4) @(negedge clk);
    check("rst_tx_a", 64'(tx_a), 64'd1);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_err_a", 64'(err_a), 64'd0);
    check("rst_word_a", 64'(data_a), 64'd0);
    check("rst_tx_b", 64'(tx_b), 64'd1);
    check("rst_word_b", 64'(data_b), 64'd0);
    out_a = 0; out_b = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_tx(0, 32'hA55A, "tx_a55a");
    run_tx(1, 32'h11223344, "tx_lsb4");

    bs[0] = 8'h12; bs[1] = 8'h34; bs[2] = 8'h00; bs[3] = 8'h00;
    run_rx(0, bs, "rx_1234");

    run_tx(0, $urandom & 32'hFFFF, "tx_rand_a");
    run_tx(1, $urandom, "tx_rand_b");

    for (int k = 0; k < 4; k++) bs[k] = 8'($urandom);
    run_rx(1, bs, "rx_rand_b");

    // Short low glitch while waiting for a start bit, then two valid frames.
    d0 = done_cnt_a;
    cmd(0, 1'b0, '0);
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (3 * BP) @(posedge clk);
    bs[0] = 8'h5A; bs[1] = 8'($urandom); bs[2] = 8'h00; bs[3] = 8'h00;
    drive_frame(0, bs[0], 1'b1);
    drive_frame(0, bs[1], 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("glitch_done_count", 64'(done_cnt_a - d0), 64'd1);
    check("glitch_rx_error", 64'(err_a), 64'd0);
    read_word(0, rd);
    check("glitch_word", 64'(rd), 64'(assemble(bs, 2, 1'b1)));
    model_word_a = assemble(bs, 2, 1'b1);

    // Framing error on the first byte: word must keep its old value.
    d0 = done_cnt_a;
    cmd(0, 1'b0, '0);
    drive_frame(0, 8'($urandom), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ferr_done_count", 64'(done_cnt_a - d0), 64'd1);
    check("ferr_rx_error", 64'(err_a), 64'd1);
    read_word(0, rd);
    check("ferr_word_kept", 64'(rd), 64'(model_word_a));
    cmd(0, 1'b0, '0);
    @(negedge clk);
    check("ferr_cleared", 64'(err_a), 64'd0);
    bs[0] = 8'($urandom); bs[1] = 8'($urandom);
    drive_frame(0, bs[0], 1'b1);
    drive_frame(0, bs[1], 1'b1);
    repeat (4) @(posedge clk);
    read_word(0, rd);
    check("ferr_recover_word", 64'(rd), 64'(assemble(bs, 2, 1'b1)));

    // Reset while the first byte's data bit 2 (word bit 10, forced low) is on the wire.
    w = $urandom & 32'h0000FBFF;
    cmd(0, 1'b1, w);
    @(posedge clk); #1 out_a = 1'b1;
    repeat (3 * BP) @(posedge clk);
    #3;
    check("rst_mid_tx_before", 64'(tx_a), 64'd0);
    check("rst_mid_data_before", 64'(data_a), 64'(w));
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 64'(tx_a), 64'd1);
    check("rst_mid_done", 64'(done_a), 64'd0);
    check("rst_mid_word", 64'(data_a), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    out_a = 1'b0;
    repeat (2) @(posedge clk);
    run_tx(0, $urandom & 32'hFFFF, "tx_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
